gemm_vec_accelerator: RTL and testbench
=======================================

// Module: gemm_vec_accelerator
// PURPOSE
// - Parametrised successor of the single-MAC GEMM engine. Computes C = A x B with NumMac parallel
//   MAC lanes, producing NumMac adjacent C columns per output word.
// - Sits between three SRAM macros: A read (scalar), B read (NumMac-wide), C write (NumMac-wide).
// - Adds a runtime signed/unsigned mode and size-legality checking with an error flag.
// PARAMETERS
// - NumMac         4   lanes, power of 2, >=1; N must be a multiple of NumMac
// - DataWidthA     8   element width of A
// - DataWidthB     8   element width of B; the B SRAM word is NumMac*DataWidthB
// - DataWidthC     32  accumulator / C element width; the C SRAM word is NumMac*DataWidthC
// - SRAMAddrWidthA 10  A SRAM word address width
// - SRAMAddrWidthB 10  B SRAM word address width
// - SRAMAddrWidthC 10  C SRAM word address width
// - SizeWidth      10  width of M/K/N size inputs
// PORTS
// - clk_i          in   1                  clock
// - rst_ni         in   1                  asynchronous reset, active low
// - start_i        in   1                  start request; sampled only in IDLE
// - signed_i       in   1                  1: operands two's complement; 0: unsigned; latched at start
// - M_size_i       in   SizeWidth          rows of A/C; latched at start
// - K_size_i       in   SizeWidth          inner dimension; latched at start
// - N_size_i       in   SizeWidth          columns of B/C; latched at start
// - sram_a_addr_o  out  SRAMAddrWidthA     A word address (row-major MxK: m*K+k)
// - sram_a_rdata_i in   DataWidthA         A data, 1-cycle read latency
// - sram_b_addr_o  out  SRAMAddrWidthB     B word address (row-major, NumMac cols/word: k*(N/NumMac)+nb)
// - sram_b_rdata_i in   NumMac*DataWidthB  B data, lane j in bits [j*DataWidthB +: DataWidthB], 1-cycle latency
// - sram_c_addr_o  out  SRAMAddrWidthC     C word address (m*(N/NumMac)+nb)
// - sram_c_wdata_o out  NumMac*DataWidthC  C data, lane j at [j*DataWidthC +: DataWidthC]
// - sram_c_we_o    out  1                  C write enable, full-word write
// - busy_o         out  1                  high while a legal job is in flight
// - done_o         out  1                  one-cycle completion pulse
// - error_o        out  1                  illegal size on the last start; held until the next accepted start
// BEHAVIOUR
// - Reset: state IDLE; all counters, accumulators, addresses and outputs 0.
// - Reset mid-job aborts immediately, with no further C writes.
// - FSM IDLE -> RUN -> FLUSH -> IDLE. start_i outside IDLE is ignored.
// - Legality check at start: M, K or N == 0, or N mod NumMac != 0, is illegal.
//   An illegal start raises done_o and error_o in cycle t+1, performs no SRAM writes, and stays in IDLE.
// - Legal start sampled at edge t: let L = M*(N/NumMac)*K.
//   - RUN issues one (m,nb,k) address pair per cycle in cycles t+1..t+L; loop order m outer, nb, k inner.
//   - Addresses are kept in incremental pointer registers (no multipliers) and wrap mod 2^SRAMAddrWidth.
// - Data pipeline: a registered valid/first_k/last_k tag follows each issue by 1 cycle to match SRAM latency.
//   - Per lane, prod = A x B[j], sign- or zero-extended to DataWidthC per the latched signed_i.
//   - first_k: acc <= prod (no clear bubble). Otherwise acc <= acc + prod, mod 2^DataWidthC.
// - C write: in the data cycle tagged last_k, sram_c_we_o = 1 and wdata = acc + prod (combinational).
//   The C address is the tag's registered c pointer. There is one write per (m,nb), with no bubbles.
// - FLUSH is 1 cycle (cycle t+L+1) and carries the final write.
// - done_o pulses in cycle t+L+2. busy_o is high in t+1..t+L+1. error_o is cleared at the accepted start.
// - K == 1: every data cycle is both first_k and last_k, so every cycle writes.
// - sram_c_we_o is never high outside RUN/FLUSH.
// STRUCTURE
// - Package gemm_vec_pkg: state_e enum {IDLE, RUN, FLUSH}; typedef lane_acc_t [DataWidthC-1:0]; the
//   pipeline tag struct {valid, first_k, last_k, c_addr}.
// - Sub-module gemm_mac_lane (one per lane, generate loop): operand extension, multiply, accumulate,
//   and the wdata output.
// - The top level holds the FSM, the m/nb/k counters, the A/B/C pointers and the legality check.
// TESTING
// - Golden models: a reference model computes C; the bench compares full C SRAM contents after each done_o.
// - NumMac=4, M=2 K=3 N=8, unsigned, A=1..6, B=1..24:
//   - 4 C words are written at addr 0..3 and match the golden model.
//   - done_o pulses exactly 14 cycles after the start edge.
// - signed_i=1, M=1 K=2 N=4, A={-1,-128}, B lanes all -128: every C lane = 0x00004080 (16512).
// - K=1, M=3 N=4: sram_c_we_o is high in 3 consecutive cycles, with C = A[m]*B lanes.
// - N=6 with NumMac=4, and separately M=0: error_o=1 and done_o pulse at t+1, zero C writes,
//   busy_o stays 0. The next legal start clears error_o.
// - start_i held high during RUN: ignored, with one done_o per job.
//   Back-to-back jobs (new start in the cycle after done_o) both verify.
// - rst_ni low mid-RUN (after 5 issues): outputs go 0 asynchronously and no writes follow.
//   A restarted full job then passes.

Source files
------------

// File: rtl/gemm_vec_pkg.sv
// gemm_vec_pkg: shared types for the vector GEMM accelerator (FSM states, accumulator lane type, pipeline tag)
package gemm_vec_pkg;
  localparam int unsigned AccWidth     = 32;
  localparam int unsigned TagAddrWidth = 10;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;
  typedef logic [AccWidth-1:0] lane_acc_t;
  typedef struct packed {
    logic                    valid;
    logic                    first_k;
    logic                    last_k;
    logic [TagAddrWidth-1:0] c_addr;
  } tag_t;
endpackage

// File: rtl/gemm_mac_lane.sv
// gemm_mac_lane: one MAC lane -- operand extension, multiply, accumulate, C write data
// Ports: clk_i/rst_ni clock and async active-low reset; signed_i operand mode;
//   valid_i/first_k_i/last_k_i pipeline tag of the current data cycle; a_i/b_i operands;
//   wdata_o accumulated result, nonzero only in a write cycle.
module gemm_mac_lane #(
  parameter int unsigned DataWidthA = 8,
  parameter int unsigned DataWidthB = 8,
  parameter int unsigned DataWidthC = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  signed_i,
  input  logic                  valid_i,
  input  logic                  first_k_i,
  input  logic                  last_k_i,
  input  logic [DataWidthA-1:0] a_i,
  input  logic [DataWidthB-1:0] b_i,
  output logic [DataWidthC-1:0] wdata_o
);
  logic [DataWidthC-1:0] a_ext, b_ext, prod, sum, acc_q;
  // Extending both operands to the accumulator width first keeps the product exact mod 2^DataWidthC.
  assign a_ext   = {{(DataWidthC-DataWidthA){signed_i & a_i[DataWidthA-1]}}, a_i};
  assign b_ext   = {{(DataWidthC-DataWidthB){signed_i & b_i[DataWidthB-1]}}, b_i};
  assign prod    = a_ext * b_ext;
  assign sum     = (first_k_i ? '0 : acc_q) + prod;
  assign wdata_o = (valid_i && last_k_i) ? sum : '0;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) acc_q <= '0;
    else if (valid_i) acc_q <= sum;
endmodule

// File: rtl/gemm_vec_accelerator.sv
// gemm_vec_accelerator: C = A x B with NumMac parallel MAC lanes, NumMac C columns per output word
// Ports: clk_i/rst_ni clock and async active-low reset; start_i/signed_i/M,K,N_size_i job request;
//   sram_a_* scalar A read; sram_b_* NumMac-wide B read; sram_c_* NumMac-wide C write;
//   busy_o job in flight; done_o completion pulse; error_o illegal size on last start.
module gemm_vec_accelerator
  import gemm_vec_pkg::*;
#(
  parameter int unsigned NumMac         = 4,
  parameter int unsigned DataWidthA     = 8,
  parameter int unsigned DataWidthB     = 8,
  parameter int unsigned DataWidthC     = 32,
  parameter int unsigned SRAMAddrWidthA = 10,
  parameter int unsigned SRAMAddrWidthB = 10,
  parameter int unsigned SRAMAddrWidthC = 10,
  parameter int unsigned SizeWidth      = 10
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic                           signed_i,
  input  logic [SizeWidth-1:0]           M_size_i,
  input  logic [SizeWidth-1:0]           K_size_i,
  input  logic [SizeWidth-1:0]           N_size_i,
  output logic [SRAMAddrWidthA-1:0]      sram_a_addr_o,
  input  logic [DataWidthA-1:0]          sram_a_rdata_i,
  output logic [SRAMAddrWidthB-1:0]      sram_b_addr_o,
  input  logic [NumMac*DataWidthB-1:0]   sram_b_rdata_i,
  output logic [SRAMAddrWidthC-1:0]      sram_c_addr_o,
  output logic [NumMac*DataWidthC-1:0]   sram_c_wdata_o,
  output logic                           sram_c_we_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           error_o
);
  localparam int unsigned Lg = $clog2(NumMac);
  state_e state_q, state_d;
  tag_t tag_q;
  logic sgn_q, done_q, err_q, legal, k_last, nb_last, m_last;
  logic [SizeWidth-1:0] m_size_q, k_size_q, nb_size_q, m_q, nb_q, k_q;
  logic [SRAMAddrWidthA-1:0] a_ptr_q, a_row_q;
  logic [SRAMAddrWidthB-1:0] b_ptr_q;
  logic [SRAMAddrWidthC-1:0] c_ptr_q;
  assign legal   = (M_size_i != '0) && (K_size_i != '0) && (N_size_i != '0) &&
                   ((N_size_i & SizeWidth'(NumMac-1)) == '0);
  assign k_last  = k_q == k_size_q - SizeWidth'(1);
  assign nb_last = nb_q == nb_size_q - SizeWidth'(1);
  assign m_last  = m_q == m_size_q - SizeWidth'(1);
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = (start_i && legal) ? RUN : IDLE;
      RUN:     state_d = (k_last && nb_last && m_last) ? FLUSH : RUN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      tag_q     <= '0;
      sgn_q     <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      m_size_q  <= '0;
      k_size_q  <= '0;
      nb_size_q <= '0;
      m_q       <= '0;
      nb_q      <= '0;
      k_q       <= '0;
      a_ptr_q   <= '0;
      a_row_q   <= '0;
      b_ptr_q   <= '0;
      c_ptr_q   <= '0;
    end else begin
      state_q       <= state_d;
      done_q        <= state_q == FLUSH;
      tag_q.valid   <= state_q == RUN;
      tag_q.first_k <= k_q == '0;
      tag_q.last_k  <= k_last;
      tag_q.c_addr  <= TagAddrWidth'(c_ptr_q);
      if (state_q == IDLE && start_i) begin
        err_q  <= !legal;
        done_q <= !legal;
        if (legal) begin
          sgn_q     <= signed_i;
          m_size_q  <= M_size_i;
          k_size_q  <= K_size_i;
          nb_size_q <= N_size_i >> Lg;
          m_q       <= '0;
          nb_q      <= '0;
          k_q       <= '0;
          a_ptr_q   <= '0;
          a_row_q   <= '0;
          b_ptr_q   <= '0;
          c_ptr_q   <= '0;
        end
      end
      // Pointers walk m*K+k, k*NB+nb and m*NB+nb by addition only; a_row_q remembers m*K.
      if (state_q == RUN) begin
        if (!k_last) begin
          k_q     <= k_q + SizeWidth'(1);
          a_ptr_q <= a_ptr_q + SRAMAddrWidthA'(1);
          b_ptr_q <= b_ptr_q + SRAMAddrWidthB'(nb_size_q);
        end else begin
          k_q     <= '0;
          c_ptr_q <= c_ptr_q + SRAMAddrWidthC'(1);
          if (!nb_last) begin
            nb_q    <= nb_q + SizeWidth'(1);
            a_ptr_q <= a_row_q;
            b_ptr_q <= SRAMAddrWidthB'(nb_q + SizeWidth'(1));
          end else begin
            nb_q    <= '0;
            m_q     <= m_q + SizeWidth'(1);
            a_row_q <= a_row_q + SRAMAddrWidthA'(k_size_q);
            a_ptr_q <= a_row_q + SRAMAddrWidthA'(k_size_q);
            b_ptr_q <= '0;
          end
        end
      end
    end
  end
  assign sram_a_addr_o = a_ptr_q;
  assign sram_b_addr_o = b_ptr_q;
  assign sram_c_addr_o = SRAMAddrWidthC'(tag_q.c_addr);
  assign sram_c_we_o   = tag_q.valid & tag_q.last_k;
  assign busy_o        = state_q != IDLE;
  assign done_o        = done_q;
  assign error_o       = err_q;
  for (genvar j = 0; j < NumMac; j++) begin : g_lane
    gemm_mac_lane #(
      .DataWidthA(DataWidthA),
      .DataWidthB(DataWidthB),
      .DataWidthC(DataWidthC)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .signed_i (sgn_q),
      .valid_i  (tag_q.valid),
      .first_k_i(tag_q.first_k),
      .last_k_i (tag_q.last_k),
      .a_i      (sram_a_rdata_i),
      .b_i      (sram_b_rdata_i[j*DataWidthB +: DataWidthB]),
      .wdata_o  (sram_c_wdata_o[j*DataWidthC +: DataWidthC])
    );
  end
endmodule

// File: tb/tb_gemm_vec_accelerator.sv
// tb_gemm_vec_accelerator: randomized and directed checks of the vector GEMM accelerator against a matrix-math model
module tb_gemm_vec_accelerator;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sgn = 1'b0, clr = 1'b0;
  logic [9:0] m_sz = '0, k_sz = '0, n_sz = '0;
  logic [9:0] a_addr, b_addr, c_addr;
  logic [7:0] a_rdata;
  logic [31:0] b_rdata;
  logic [127:0] c_wdata;
  logic c_we, busy, done, err;
  logic [7:0] amem [64];
  logic [31:0] bmem [64];
  logic [127:0] cmem [64];
  int wr_cnt = 0, done_cnt = 0, tests = 0, fails = 0;

  gemm_vec_accelerator dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .signed_i(sgn),
    .M_size_i(m_sz), .K_size_i(k_sz), .N_size_i(n_sz),
    .sram_a_addr_o(a_addr), .sram_a_rdata_i(a_rdata),
    .sram_b_addr_o(b_addr), .sram_b_rdata_i(b_rdata),
    .sram_c_addr_o(c_addr), .sram_c_wdata_o(c_wdata), .sram_c_we_o(c_we),
    .busy_o(busy), .done_o(done), .error_o(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    a_rdata  <= amem[a_addr[5:0]];
    b_rdata  <= bmem[b_addr[5:0]];
    done_cnt <= done_cnt + int'(done);
    if (clr) for (int i = 0; i < 64; i++) cmem[i] <= {4{32'hA5A5_5A5A}};
    else if (c_we) begin
      cmem[c_addr[5:0]] <= c_wdata;
      wr_cnt <= wr_cnt + 1;
    end
  end

  function automatic int c_bad(int m, int k, int n, bit s);
    int nb, bad;
    longint acc, av, bv;
    logic [127:0] exp;
    logic [31:0] bw;
    logic [7:0] ae, be;
    nb = n / 4;
    bad = 0;
    for (int mm = 0; mm < m; mm++)
      for (int bb = 0; bb < nb; bb++) begin
        for (int j = 0; j < 4; j++) begin
          acc = 0;
          for (int kk = 0; kk < k; kk++) begin
            ae = amem[mm*k+kk];
            bw = bmem[kk*nb+bb];
            be = bw[j*8 +: 8];
            av = s ? longint'($signed(ae)) : longint'(ae);
            bv = s ? longint'($signed(be)) : longint'(be);
            acc += av * bv;
          end
          exp[j*32 +: 32] = acc[31:0];
        end
        if (cmem[mm*nb+bb] !== exp) bad++;
      end
    return bad;
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) begin
      amem[i] = 8'($urandom);
      bmem[i] = $urandom;
    end
  endtask

  task automatic clear_c();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic go(input int m, input int k, input int n, input bit s);
    @(negedge clk);
    m_sz = 10'(m); k_sz = 10'(k); n_sz = 10'(n); sgn = s; start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 4000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    tests++;
    if ({busy, done, err, c_we} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b want 0000", {busy, done, err, c_we});
    end
    tests++;
    if ({a_addr, b_addr, c_addr} !== 30'b0 || c_wdata !== '0) begin
      fails++;
      $display("FAIL reset_outputs: addr %h/%h/%h wdata %h want 0", a_addr, b_addr, c_addr, c_wdata);
    end
  endtask

  task automatic test_basic();
    int lat, w0, bad;
    for (int i = 0; i < 6; i++) amem[i] = 8'(i + 1);
    for (int w = 0; w < 6; w++) bmem[w] = {8'(w*4+4), 8'(w*4+3), 8'(w*4+2), 8'(w*4+1)};
    clear_c();
    w0 = wr_cnt;
    go(2, 3, 8, 1'b0);
    wait_done(lat);
    tests++;
    if (lat != 14) begin fails++; $display("FAIL basic_latency: got %0d want 14", lat); end
    tests++;
    if (wr_cnt - w0 != 4) begin fails++; $display("FAIL basic_writes: got %0d want 4", wr_cnt - w0); end
    bad = c_bad(2, 3, 8, 1'b0);
    tests++;
    if (bad != 0) begin fails++; $display("FAIL basic_c: %0d bad words want 0", bad); end
  endtask

  task automatic test_signed();
    int lat, bad;
    amem[0] = 8'hFF; amem[1] = 8'h80;
    bmem[0] = 32'h8080_8080; bmem[1] = 32'h8080_8080;
    clear_c();
    go(1, 2, 4, 1'b1);
    wait_done(lat);
    tests++;
    if (cmem[0] !== {4{32'h0000_4080}}) begin
      fails++; $display("FAIL signed_c: got %h want %h", cmem[0], {4{32'h0000_4080}});
    end
    bad = c_bad(1, 2, 4, 1'b1);
    tests++;
    if (bad != 0) begin fails++; $display("FAIL signed_model: %0d bad words want 0", bad); end
  endtask

  task automatic test_k1();
    int lat, ones, breaks, bad;
    bit prev;
    fill_rand();
    clear_c();
    ones = 0; breaks = 0; prev = 1'b0;
    go(3, 1, 4, 1'b0);
    lat = 1;
    while (done !== 1'b1 && lat < 4000) begin
      if (c_we) begin
        if (ones != 0 && !prev) breaks++;
        ones++;
      end
      prev = c_we;
      @(negedge clk);
      lat++;
    end
    tests++;
    if (ones != 3 || breaks != 0) begin
      fails++; $display("FAIL k1_we: got %0d writes %0d gaps want 3 writes 0 gaps", ones, breaks);
    end
    bad = c_bad(3, 1, 4, 1'b0);
    tests++;
    if (bad != 0) begin fails++; $display("FAIL k1_c: %0d bad words want 0", bad); end
  endtask

  task automatic test_illegal();
    int w0, busy_seen, dn, lat, bad;
    int cfg [2][3] = '{'{1, 2, 6}, '{0, 2, 4}};
    for (int c = 0; c < 2; c++) begin
      w0 = wr_cnt; busy_seen = 0; dn = 0;
      go(cfg[c][0], cfg[c][1], cfg[c][2], 1'b0);
      tests++;
      if (done !== 1'b1 || err !== 1'b1 || busy !== 1'b0) begin
        fails++; $display("FAIL illegal%0d_t1: done %b err %b busy %b want 1 1 0", c, done, err, busy);
      end
      repeat (6) begin
        @(negedge clk);
        busy_seen += int'(busy);
        dn += int'(done);
      end
      tests++;
      if (busy_seen != 0 || dn != 0 || err !== 1'b1 || wr_cnt != w0) begin
        fails++;
        $display("FAIL illegal%0d_after: busy %0d done %0d err %b writes %0d want 0 0 1 0", c, busy_seen, dn, err, wr_cnt - w0);
      end
    end
    fill_rand();
    clear_c();
    go(1, 1, 4, 1'b0);
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL illegal_clear: err %b want 0", err); end
    wait_done(lat);
    bad = c_bad(1, 1, 4, 1'b0);
    tests++;
    if (bad != 0) begin fails++; $display("FAIL illegal_recover_c: %0d bad words want 0", bad); end
  endtask

  task automatic test_start_held();
    int d0, lat, bad;
    fill_rand();
    clear_c();
    d0 = done_cnt;
    @(negedge clk);
    m_sz = 10'd2; k_sz = 10'd3; n_sz = 10'd8; sgn = 1'b1; start = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    repeat (30) @(negedge clk);
    tests++;
    if (done_cnt - d0 != 1) begin fails++; $display("FAIL held_done: got %0d pulses want 1", done_cnt - d0); end
    bad = c_bad(2, 3, 8, 1'b1);
    tests++;
    if (bad != 0) begin fails++; $display("FAIL held_c: %0d bad words want 0", bad); end
  endtask

  task automatic test_back_to_back();
    int lat, bad;
    fill_rand();
    clear_c();
    go(2, 2, 4, 1'b0);
    wait_done(lat);
    bad = c_bad(2, 2, 4, 1'b0);
    tests++;
    if (bad != 0 || lat != 6) begin fails++; $display("FAIL b2b_job1: %0d bad words lat %0d want 0 6", bad, lat); end
    m_sz = 10'd3; k_sz = 10'd4; n_sz = 10'd8; sgn = 1'b1; start = 1'b1; clr = 1'b1;
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    wait_done(lat);
    bad = c_bad(3, 4, 8, 1'b1);
    tests++;
    if (bad != 0 || lat != 26) begin fails++; $display("FAIL b2b_job2: %0d bad words lat %0d want 0 26", bad, lat); end
  endtask

  task automatic test_reset_midrun();
    int w0, lat, bad;
    fill_rand();
    clear_c();
    go(2, 3, 8, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({busy, done, err, c_we} !== 4'b0 || c_wdata !== '0 || {a_addr, b_addr, c_addr} !== 30'b0) begin
      fails++; $display("FAIL midrst_outputs: flags %b wdata %h want 0", {busy, done, err, c_we}, c_wdata);
    end
    w0 = wr_cnt;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    tests++;
    if (wr_cnt != w0 || busy !== 1'b0) begin
      fails++; $display("FAIL midrst_quiet: %0d writes busy %b want 0 0", wr_cnt - w0, busy);
    end
    clear_c();
    go(2, 3, 8, 1'b0);
    wait_done(lat);
    bad = c_bad(2, 3, 8, 1'b0);
    tests++;
    if (bad != 0 || lat != 14) begin fails++; $display("FAIL midrst_rerun: %0d bad words lat %0d want 0 14", bad, lat); end
  endtask

  task automatic test_random();
    int m, k, n, lat, w0, bad, want;
    bit s;
    for (int r = 0; r < 8; r++) begin
      m = int'($urandom_range(1, 4));
      k = int'($urandom_range(1, 5));
      n = 4 * int'($urandom_range(1, 3));
      s = 1'($urandom);
      want = m * (n / 4) * k + 2;
      fill_rand();
      clear_c();
      w0 = wr_cnt;
      go(m, k, n, s);
      wait_done(lat);
      bad = c_bad(m, k, n, s);
      tests++;
      if (bad != 0 || lat != want || wr_cnt - w0 != m * (n / 4)) begin
        fails++;
        $display("FAIL random%0d M%0d K%0d N%0d s%0d: bad %0d lat %0d writes %0d want 0 %0d %0d",
                 r, m, k, n, s, bad, lat, wr_cnt - w0, want, m * (n / 4));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin amem[i] = '0; bmem[i] = '0; end
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_basic();
    test_signed();
    test_k1();
    test_illegal();
    test_start_held();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
